// File: rtl/window_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : window_accumulator
// Description : Sums WINDOW accepted 8-bit samples into an ACC_W-bit total and
//               presents it on a valid/ready output with a per-window overflow
//               flag. Define SUM_ACC_SAT_EN to clamp the accumulator instead of
//               letting it wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module window_accumulator #(
    parameter int WINDOW = 8,
    parameter int ACC_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_data,
    output logic             ovf,
    input  logic             out_ready
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;
    localparam logic [7:0] c_window   = 8'(WINDOW);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_next;
    logic [7:0]       r_count;
    logic [7:0]       w_count_next;
    logic [7:0]       w_count_inc;
    logic             r_ovf_int;
    logic             w_ovf_int_next;
    logic [ACC_W-1:0] r_out_data;
    logic             r_ovf;
    logic             w_beat;
    logic             w_take;
    logic             w_last;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_sum;

    assign in_ready    = (r_state != c_st_hold);
    assign out_valid   = (r_state == c_st_hold);
    assign out_data    = r_out_data;
    assign ovf         = r_ovf;

    assign w_beat      = in_valid && in_ready;
    assign w_take      = out_valid && out_ready;
    assign w_count_inc = r_count + 8'd1;
    assign w_last      = w_beat && !clear && (w_count_inc == c_window);

    // One extra bit so the carry out of the accumulator is visible as overflow
    assign w_sum = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, in_data};

`ifdef SUM_ACC_SAT_EN
    localparam logic [ACC_W-1:0] c_acc_max = '1;
    // Once clamped, stay clamped until the window ends
    assign w_acc_sum = (w_sum[ACC_W] || r_ovf_int) ? c_acc_max : w_sum[ACC_W-1:0];
`else
    assign w_acc_sum = w_sum[ACC_W-1:0];
`endif

    always_comb begin
        w_state_next   = r_state;
        w_acc_next     = r_acc;
        w_count_next   = r_count;
        w_ovf_int_next = r_ovf_int;
        if (clear) begin
            w_state_next   = c_st_idle;
            w_acc_next     = '0;
            w_count_next   = '0;
            w_ovf_int_next = 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_accum: begin
                    if (w_beat) begin
                        w_acc_next     = w_acc_sum;
                        w_count_next   = w_count_inc;
                        w_ovf_int_next = r_ovf_int | w_sum[ACC_W];
                        w_state_next   = (w_count_inc == c_window) ? c_st_hold : c_st_accum;
                    end
                end
                c_st_hold: begin
                    if (w_take) begin
                        w_state_next   = c_st_idle;
                        w_acc_next     = '0;
                        w_count_next   = '0;
                        w_ovf_int_next = 1'b0;
                    end
                end
                default: w_state_next = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_acc      <= '0;
            r_count    <= '0;
            r_ovf_int  <= 1'b0;
            r_out_data <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_acc     <= w_acc_next;
            r_count   <= w_count_next;
            r_ovf_int <= w_ovf_int_next;
            // out_data survives a clear; only the flag is withdrawn
            if (clear) begin
                r_ovf <= 1'b0;
            end else if (w_last) begin
                r_out_data <= w_acc_sum;
                r_ovf      <= w_ovf_int_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_window_accumulator.sv
`timescale 1ns/1ps
`default_nettype none
// Randomised scoreboard bench for window_accumulator (WINDOW=8, ACC_W=10).
module tb_window_accumulator;

    localparam int WINDOW  = 8;
    localparam int ACC_W   = 10;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    typedef struct {
        int data;
        bit ovf;
    } result_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] out_data;
    logic             ovf;
    logic             out_ready;

    int      n_tests = 0;
    int      n_fail  = 0;
    result_t exp_q[$];
    int      win[$];
    bit      m_hold     = 1'b0;
    int      m_out_data = 0;
    bit      m_ovf      = 1'b0;

    always #5 clk = ~clk;

    window_accumulator #(.WINDOW(WINDOW), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ovf       (ovf),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: the window total is just the plain integer sum of its samples
    task automatic close_window();
        int      total;
        result_t r;
        total = 0;
        foreach (win[i]) total += win[i];
        r.ovf = (total > ACC_MAX);
`ifdef SUM_ACC_SAT_EN
        r.data = r.ovf ? ACC_MAX : total;
`else
        r.data = total % (ACC_MAX + 1);
`endif
        exp_q.push_back(r);
        m_out_data = r.data;
        m_ovf      = r.ovf;
        m_hold     = 1'b1;
        win.delete();
    endtask

    // Called at a negedge: checks visible state, applies inputs for the next edge
    task automatic drive(input bit v, input logic [7:0] d, input bit rdy, input bit clr);
        check("in_ready", in_ready, !m_hold);
        check("out_valid", out_valid, m_hold);
        check("out_data", out_data, m_out_data);
        check("ovf", ovf, m_ovf);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        clear     = clr;
        if (clr) begin
            if (m_hold) void'(exp_q.pop_front());
            m_hold = 1'b0;
            m_ovf  = 1'b0;
            win.delete();
        end else if (m_hold) begin
            if (rdy) m_hold = 1'b0;
        end else if (v) begin
            win.push_back(int'(d));
            if (win.size() == WINDOW) close_window();
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 8'($urandom), rdy, 1'b0);
    endtask

    // Monitor: pops on a real handshake, checks the held value while stalled
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && !clear && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got out_valid=1 data=%0d expected no pending result", out_data);
                end else if (out_ready) begin
                    result_t r;
                    r = exp_q.pop_front();
                    check("result_data", out_data, r.data);
                    check("result_ovf", ovf, r.ovf);
                end else begin
                    check("held_data", out_data, exp_q[0].data);
                    check("held_ovf", ovf, exp_q[0].ovf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic window 1..8
        for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Overflow window, then a clean window
        repeat (8) drive(1'b1, 8'd255, 1'b1, 1'b0);
        idle(1'b1);
        repeat (8) drive(1'b1, 8'd1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Backpressure with input traffic that must be refused
        repeat (8) drive(1'b1, 8'd10, 1'b0, 1'b0);
        repeat (5) drive(1'b1, 8'd99, 1'b0, 1'b0);
        idle(1'b1);
        repeat (8) drive(1'b1, 8'd1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Random gaps between beats
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) idle(1'b1);
            drive(1'b1, 8'd3, 1'b1, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        // Clear mid-window drops the coincident beat
        repeat (3) drive(1'b1, 8'd10, 1'b1, 1'b0);
        drive(1'b1, 8'd50, 1'b1, 1'b1);
        repeat (8) drive(1'b1, 8'd1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Clear during HOLD of an overflowed window, with out_ready high
        repeat (8) drive(1'b1, 8'd200, 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b0, 8'd0, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset while a result is held
        repeat (8) drive(1'b1, 8'd255, 1'b0, 1'b0);
        idle(1'b0);
        check("pre_reset_out_valid", out_valid, 1);
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        #2;
        rst = 1'b1;
        if (m_hold) void'(exp_q.pop_front());
        m_hold = 1'b0; m_out_data = 0; m_ovf = 1'b0; win.delete();
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_ovf", ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic with occasional clears
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 10) < 7, 8'($urandom), ($urandom % 10) < 6, ($urandom % 40) == 0);
        end
        repeat (3) idle(1'b1);
        #2;
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
